// File: rtl/store_merge_pkg.sv
// store_merge_pkg: shared types for the store merge unit.
//   state_e : 2-bit FSM encoding (IDLE, RD, MERGE, WR)
//   size_e  : store size codes (BYTE, HALF, WORD)
//   size_of : decodes the SB/SH request strobes into a size code
package store_merge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    MERGE = 2'd2,
    WR    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_e;

  // Both strobes set is rejected before this is used, so SB wins arbitrarily.
  function automatic size_e size_of(input logic sb, input logic sh);
    if (sb)      return BYTE;
    else if (sh) return HALF;
    else         return WORD;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// byte_lane_merge: little-endian lane merge of a sub-word store into an
// existing memory word. Purely combinational.
//   old_i    : word previously read from memory
//   new_i    : right-aligned store data
//   offset_i : byte offset within the word (addr[1:0])
//   size_i   : BYTE / HALF / WORD (store_merge_pkg::size_e encoding)
//   merged_o : word to write back
module byte_lane_merge
  import store_merge_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    case (size_i)
      BYTE: begin
        case (offset_i)
          2'd0: merged_o[7:0]   = new_i[7:0];
          2'd1: merged_o[15:8]  = new_i[7:0];
          2'd2: merged_o[23:16] = new_i[7:0];
          2'd3: merged_o[31:24] = new_i[7:0];
          default: merged_o = old_i;
        endcase
      end
      // offset_i[0] is deliberately ignored: a halfword always lands on the
      // half selected by offset_i[1].
      HALF: begin
        if (offset_i[1]) merged_o[31:16] = new_i[15:0];
        else             merged_o[15:0]  = new_i[15:0];
      end
      default: merged_o = new_i;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// store_merge_unit: turns byte/halfword/word stores into whole-word
// accesses on a word-addressed memory port (read-modify-write for sub-word
// stores, a single write for word stores).
//   clk, rst_n           : clock, synchronous active-low reset
//   req, addr, wdata     : store request (accepted when req && ready)
//   SB, SH               : byte / halfword store strobes (both 0 = word)
//   ready, done, err     : idle flag, write-cycle pulse, reject pulse
//   mem_addr, mem_rd,
//   mem_rdata, mem_wr,
//   mem_wdata            : memory port; read data arrives one cycle after mem_rd
// Build option: STORE_MERGE_MISALIGN_ERR_EN rejects halfword stores with
// addr[0]=1; without it, addr[0] is ignored for halfwords.
//
// state | meaning
// IDLE  | ready for a request
// RD    | mem_rd issued for the target word
// MERGE | memory returns old word; captured at the end of this cycle
// WR    | merged (or full) word written, done pulses
module store_merge_unit
  import store_merge_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic          SB,
  input  logic          SH,
  output logic          ready,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [31:0]   mem_rdata,
  output logic          mem_wr,
  output logic [31:0]   mem_wdata
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  size_e         size_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          accept;
  logic          reject;
  logic [31:0]   merged;

  assign accept = req && (state_q == IDLE);

`ifdef STORE_MERGE_MISALIGN_ERR_EN
  assign reject = (SB && SH) || (SH && addr[0]);
`else
  assign reject = SB && SH;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && !reject) state_d = (SB || SH) ? RD : WR;
      end
      RD:      state_d = MERGE;
      MERGE:   state_d = WR;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= BYTE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && reject;
      if (accept && !reject) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        size_q  <= size_of(SB, SH);
      end
      if (state_q == MERGE) rdata_q <= mem_rdata;
    end
  end

  byte_lane_merge u_merge (
    .old_i    (rdata_q),
    .new_i    (wdata_q),
    .offset_i (addr_q[1:0]),
    .size_i   (size_q),
    .merged_o (merged)
  );

  assign ready     = (state_q == IDLE);
  assign mem_rd    = (state_q == RD);
  assign mem_wr    = (state_q == WR);
  assign done      = (state_q == WR);
  assign err       = err_q;
  assign mem_addr  = {addr_q[AW-1:2], 2'b00};
  assign mem_wdata = (state_q == WR) ? merged : 32'h0;

endmodule

// File: tb/tb_store_merge_unit.sv
// Testbench for store_merge_unit: directed stores against a behavioural
// memory, with a per-cycle schedule of expected port activity built from
// the request rules and checked by one compare process.
module tb_store_merge_unit;

  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        SB = 1'b0;
  logic        SH = 1'b0;
  logic        ready, done, err;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata = '0;
  logic        mem_wr;
  logic [31:0] mem_wdata;

  store_merge_unit #(.AW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .addr      (addr),
    .wdata     (wdata),
    .SB        (SB),
    .SH        (SH),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory preload handshake
  logic       poke_en = 1'b0;
  logic [7:0] poke_idx = '0;
  logic [31:0] poke_val = '0;

  // memory responder: one-cycle read latency
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    if (mem_wr)  mem[mem_addr[9:2]] <= mem_wdata;
    if (mem_rd)  mem_rdata <= mem[mem_addr[9:2]];
  end

  // expected per-cycle schedule (written only by the driver)
  bit          exp_ready [0:N-1];
  bit          exp_rd    [0:N-1];
  bit          exp_wr    [0:N-1];
  bit          exp_err   [0:N-1];
  logic [31:0] exp_addr  [0:N-1];
  logic [31:0] w_a       [0:N-1];
  logic [31:0] w_d       [0:N-1];
  bit          w_sb      [0:N-1];
  bit          w_sh      [0:N-1];
  bit          lit_v     [0:N-1];
  logic [31:0] lit       [0:N-1];

  bit chk_en = 1'b0;
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // compare process: owns the reference memory and all counters
  initial begin : compare
    logic [31:0] model_mem [0:255];
    logic [31:0] old_w, e;
    int c, sh;
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    forever begin
      @(negedge clk);
      if (poke_en) model_mem[poke_idx] = poke_val;
      if (chk_en) begin
        c = cyc;
        chk("ready",  {31'b0, ready},  {31'b0, exp_ready[c]});
        chk("mem_rd", {31'b0, mem_rd}, {31'b0, exp_rd[c]});
        chk("mem_wr", {31'b0, mem_wr}, {31'b0, exp_wr[c]});
        chk("done",   {31'b0, done},   {31'b0, exp_wr[c]});
        chk("err",    {31'b0, err},    {31'b0, exp_err[c]});
        if (exp_rd[c]) chk("rd_addr", mem_addr, exp_addr[c]);
        if (exp_wr[c]) begin
          old_w = model_mem[w_a[c][9:2]];
          if (w_sb[c]) begin
            sh = 8 * int'(w_a[c][1:0]);
            e  = (old_w & ~(32'hFF << sh)) | ((w_d[c] & 32'hFF) << sh);
          end else if (w_sh[c]) begin
            sh = 16 * int'(w_a[c][1]);
            e  = (old_w & ~(32'hFFFF << sh)) | ((w_d[c] & 32'hFFFF) << sh);
          end else begin
            e = w_d[c];
          end
          chk("wr_addr", mem_addr, w_a[c] & 32'hFFFF_FFFC);
          chk("wr_data", mem_wdata, e);
          if (lit_v[c]) begin
            chk("wr_data_lit", mem_wdata, lit[c]);
            chk("model_lit", e, lit[c]);
          end
          model_mem[w_a[c][9:2]] = e;
        end else begin
          chk("wdata_idle", mem_wdata, 32'h0);
        end
      end
    end
  end

  // all driver tasks are entered #1 after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) step();
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] val);
    poke_en = 1'b1;
    poke_idx = idx;
    poke_val = val;
    step();
    poke_en = 1'b0;
  endtask

  task automatic schedule(input int k, input logic [31:0] a, input logic [31:0] d,
                          input bit sb, input bit sh, input bit lv, input logic [31:0] lval);
    bit rej;
    int w;
    rej = sb && sh;
`ifdef STORE_MERGE_MISALIGN_ERR_EN
    rej = rej || (sh && a[0]);
`endif
    if (rej) begin
      exp_err[k+1] = 1'b1;
    end else begin
      if (sb || sh) begin
        for (int j = 1; j <= 3; j++) exp_ready[k+j] = 1'b0;
        exp_rd[k+1]   = 1'b1;
        exp_addr[k+1] = a & 32'hFFFF_FFFC;
        w = k + 3;
      end else begin
        exp_ready[k+1] = 1'b0;
        w = k + 1;
      end
      exp_wr[w] = 1'b1;
      w_a[w]    = a;
      w_d[w]    = d;
      w_sb[w]   = sb;
      w_sh[w]   = sh;
      lit_v[w]  = lv;
      lit[w]    = lval;
    end
  endtask

  // presents a store and holds req until the model says it is accepted
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input bit sb,
                       input bit sh, input bit lv, input logic [31:0] lval, output int acc);
    acc = -1;
    req = 1'b1; addr = a; wdata = d; SB = sb; SH = sh;
    for (int n = 0; n < 20; n++) begin
      if (exp_ready[cyc]) begin
        acc = cyc;
        schedule(cyc, a, d, sb, sh, lv, lval);
        step();
        break;
      end
      step();
    end
    if (acc < 0) begin
      total++;
      bad++;
      $display("FAIL accept_timeout cyc=%0d got=none want=accept", cyc);
    end
    req = 1'b0;
  endtask

  initial begin : driver
    int k;
    for (int i = 0; i < N; i++) exp_ready[i] = 1'b1;

    // reset state
    rst_n = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
    idle(2);

    // byte store into lane 3
    poke(8'd64, 32'h1122_3344);
    issue(32'h103, 32'hAB, 1, 0, 1, 32'hAB22_3344, k);
    idle(4);

    // halfword store into upper half
    poke(8'd64, 32'h1122_3344);
    issue(32'h102, 32'hBEEF, 0, 1, 1, 32'hBEEF_3344, k);
    idle(4);

    // word store: single write, no read
    poke(8'd65, 32'h0);
    issue(32'h104, 32'hDEAD_BEEF, 0, 0, 1, 32'hDEAD_BEEF, k);
    idle(3);

    // word store with nonzero low address bits
    issue(32'h107, 32'hCAFE_F00D, 0, 0, 1, 32'hCAFE_F00D, k);
    idle(3);

    // halfword at odd address
    poke(8'd64, 32'h1122_3344);
    issue(32'h101, 32'hBEEF, 0, 1, 1, 32'h1122_BEEF, k);
    idle(4);

    // req held high: second store waits until the first has written
    poke(8'd64, 32'h1122_3344);
    issue(32'h100, 32'h55, 1, 0, 1, 32'h1122_3355, k);
    issue(32'h101, 32'h66, 1, 0, 1, 32'h1122_6655, k);
    idle(5);

    // reset in MERGE aborts the store
    poke(8'd64, 32'h1122_3344);
    issue(32'h102, 32'h77, 1, 0, 0, 32'h0, k);
    step();
    rst_n = 1'b0;
    exp_wr[k+3]    = 1'b0;
    exp_ready[k+3] = 1'b1;
    step();
    rst_n = 1'b1;
    idle(2);
    issue(32'h100, 32'h01, 1, 0, 1, 32'h1122_3301, k);
    idle(4);

    // both strobes set: rejected
    issue(32'h100, 32'h1234_5678, 1, 1, 0, 32'h0, k);
    idle(3);

    // further lanes on the surviving word
    issue(32'h100, 32'h1234_5678, 0, 1, 1, 32'h1122_5678, k);
    issue(32'h102, 32'h0000_00C3, 1, 0, 1, 32'h11C3_5678, k);
    idle(5);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_merge_unit.md
STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 SHALL have parameter AW, default 32: byte-address width.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port req, input, 1: store request, accepted when req && ready.
REQ-005 SHALL have port addr, input, AW: byte address of the store.
REQ-006 SHALL have port wdata, input, 32: store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-007 SHALL have ports SB and SH, input, 1 each: byte store and halfword store; both 0 means word store.
REQ-008 SHALL have port ready, output, 1: high only in IDLE.
REQ-009 SHALL have port done, output, 1: one-cycle pulse in the write cycle.
REQ-010 SHALL have port err, output, 1: one-cycle pulse on a rejected request.
REQ-011 SHALL have ports mem_addr (output, AW), mem_rd (output, 1), mem_rdata (input, 32), mem_wr (output, 1) and mem_wdata (output, 32), forming a word-addressed memory port.

Function
REQ-012 SHALL latch addr, wdata, SB and SH on accept; req while not ready SHALL be ignored.
REQ-013 SHALL drive mem_addr = {addr[AW-1:2], 2'b00} from the latched address.
REQ-014 SHALL use states IDLE, RD, MERGE and WR.
- Byte or halfword store: IDLE -> RD -> MERGE -> WR -> IDLE.
- Word store: IDLE -> WR -> IDLE.
REQ-015 SHALL hold mem_rd=1 for exactly the RD cycle; memory returns mem_rdata one cycle later, captured in MERGE.
REQ-016 SHALL hold mem_wr=1 and done=1 for exactly the WR cycle.
REQ-017 Latency from the accept edge: byte or halfword stores SHALL write in cycle 3; word stores SHALL write in cycle 1 with no mem_rd.
REQ-018 Byte-lane merge is little-endian.
- SB replaces lane addr[1:0] (lane 0 = [7:0]) with wdata[7:0].
- SH replaces bits [15:0] if addr[1]=0, else [31:16], with wdata[15:0].
- All other bits SHALL equal the captured mem_rdata.
REQ-019 A word store SHALL write wdata unchanged; addr[1:0] SHALL be ignored.
REQ-020 SB=1 and SH=1 together SHALL be rejected: err pulse in the cycle after accept, no memory access, return to IDLE.
REQ-021 mem_wdata SHALL be 0 outside WR.
REQ-022 ready SHALL be 1 again in the cycle after WR, so back-to-back stores are possible.

Reset
REQ-023 On rst_n=0 at a clock edge: state SHALL become IDLE and all registers and outputs SHALL become 0 (ready=1 when rst_n=0 sampled).
REQ-024 Reset during RD or MERGE SHALL abort: no mem_wr SHALL ever be issued for the aborted store.

Configuration
REQ-025 With macro STORE_MERGE_MISALIGN_ERR_EN defined, SH with addr[0]=1 SHALL be rejected: err pulse in the cycle after accept, no mem_rd or mem_wr.
REQ-026 Without STORE_MERGE_MISALIGN_ERR_EN, addr[0] SHALL be ignored for SH and the store SHALL proceed as aligned; err then pulses only for the case in REQ-020.

Structure
REQ-027 Package store_merge_pkg SHALL hold the state encoding (2 bits) and the size codes BYTE, HALF and WORD.
REQ-028 The combinational lane merge SHALL be sub-module byte_lane_merge (inputs: old word, new data, offset, size; output: merged word).

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- SB addr=0x103, wdata=0xAB, mem word 0x11223344 -> mem_rd in cycle 1 at 0x100; mem_wr in cycle 3 with 0xAB223344 and done=1.
- SH addr=0x102, wdata=0xBEEF, mem 0x11223344 -> mem_wr cycle 3 with 0xBEEF3344.
- Word store addr=0x104, wdata=0xDEADBEEF -> mem_wr in cycle 1 at 0x104; mem_rd never asserted.
- SH addr=0x101, wdata=0xBEEF:
  - with macro -> err pulse in cycle 1, no memory access;
  - without macro -> write 0x1122BEEF to 0x100.
- req held high during a byte store -> second store is accepted only after WR, not earlier.
- rst_n=0 in MERGE -> mem_wr stays 0; ready=1 the next cycle.
- SB=SH=1 -> err pulse in cycle 1, no memory access.
